// File: rtl/motor_cmd_framer.sv
// Turns the one-hot motor command into a 4-byte UART frame (HEADER, CMD, SPEED, CHK),
// resent on command change, once after reset, and periodically as a keep-alive.
module motor_cmd_framer #(
   parameter logic [7:0] HEADER         = 8'hAA,
   parameter int         REFRESH_CYCLES = 5_000_000,
   parameter int         CNT_W          = 24
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [4:0]  motor_state,
   input  logic [7:0]  speed,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic [15:0] frame_count
);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_CMD, S_SPD, S_CHK} state_t;

   localparam bit             REF_EN   = (REFRESH_CYCLES != 0);
   localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_CYCLES - 1);

   state_t            state_q, state_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_valid_q, tx_valid_d;
   logic [15:0]       fc_q, fc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pending_q, pending_d;
   logic [2:0]        last_code_q, last_code_d;
   logic [2:0]        cmd_q, cmd_d;
   logic [7:0]        spd_q, spd_d;
   logic [2:0]        code;
   logic              accept;
   logic              refresh_exp;

   // Anything that is not exactly one-hot is treated as stop.
   always_comb begin
      case (motor_state)
         5'b00001: code = 3'd0;
         5'b00010: code = 3'd1;
         5'b00100: code = 3'd2;
         5'b01000: code = 3'd3;
         5'b10000: code = 3'd4;
         default:  code = 3'd0;
      endcase
   end

   assign accept      = tx_valid_q && tx_ready;
   assign refresh_exp = REF_EN && (cnt_q == REF_LAST);

   always_comb begin
      state_d     = state_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      fc_d        = fc_q;
      cnt_d       = cnt_q;
      pending_d   = pending_q;
      last_code_d = last_code_q;
      cmd_d       = cmd_q;
      spd_d       = spd_q;
      if (state_q == S_IDLE) begin
         if (code != last_code_q || pending_q || refresh_exp) begin
            cmd_d       = code;
            spd_d       = speed;
            last_code_d = code;
            pending_d   = 1'b0;
            cnt_d       = '0;
            state_d     = S_HDR;
            tx_data_d   = HEADER;
            tx_valid_d  = 1'b1;
         end else if (REF_EN) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         // A change during the frame is remembered and sent right after it.
         if (code != cmd_q) pending_d = 1'b1;
         if (accept) begin
            case (state_q)
               S_HDR: begin state_d = S_CMD; tx_data_d = {5'b0, cmd_q}; end
               S_CMD: begin state_d = S_SPD; tx_data_d = spd_q; end
               S_SPD: begin state_d = S_CHK; tx_data_d = HEADER ^ {5'b0, cmd_q} ^ spd_q; end
               S_CHK: begin state_d = S_IDLE; tx_valid_d = 1'b0; fc_d = fc_q + 16'd1; end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         fc_q        <= '0;
         cnt_q       <= '0;
         pending_q   <= 1'b0;
         last_code_q <= 3'h7;
         cmd_q       <= '0;
         spd_q       <= '0;
      end else begin
         state_q     <= state_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         fc_q        <= fc_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         last_code_q <= last_code_d;
         cmd_q       <= cmd_d;
         spd_q       <= spd_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign busy        = (state_q != S_IDLE);
   assign frame_count = fc_q;

endmodule

// File: tb/tb_motor_cmd_framer.sv
// Bench for motor_cmd_framer: directed scenarios plus randomized frames checked
// against a frame model built from the code map and XOR checksum.
module tb_motor_cmd_framer;
   localparam int REF = 20;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic [4:0]  motor_state;
   logic [7:0]  speed;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic [15:0] frame_count;

   int          errs = 0;
   int          checks = 0;
   int          exp_fc = 0;
   logic [7:0]  last_sent;
   logic [7:0]  got [4];
   int          first_cyc, last_cyc;
   bit          timeout;

   motor_cmd_framer #(.HEADER(8'hAA), .REFRESH_CYCLES(REF), .CNT_W(24)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .motor_state(motor_state), .speed(speed),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
      .frame_count(frame_count)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   function automatic logic [7:0] ref_code(input logic [4:0] ms);
      ref_code = 8'h00;
      if ($countones(ms) == 1)
         for (int i = 0; i < 5; i++) if (ms[i]) ref_code = 8'(i);
   endfunction

   function automatic logic [31:0] ref_frame(input logic [4:0] ms, input logic [7:0] sp);
      logic [7:0] c;
      c = ref_code(ms);
      return {8'hAA, c, sp, 8'hAA ^ c ^ sp};
   endfunction

   // Accepts one frame; inputs driven and outputs sampled on the falling edge.
   task automatic collect(input int ready_pct, input int chg_after, input logic [4:0] chg_ms);
      int n = 0;
      int cyc = 0;
      timeout = 0; first_cyc = -1; last_cyc = -1;
      for (int i = 0; i < 4; i++) got[i] = 'x;
      while (n < 4) begin
         @(negedge CLOCK_50); cyc++;
         if (chg_after >= 0 && n == chg_after) motor_state = chg_ms;
         tx_ready = ($urandom_range(99) < ready_pct);
         if (tx_valid && tx_ready) begin
            if (n == 0) first_cyc = cyc;
            if (n == 3) last_cyc = cyc;
            got[n] = tx_data;
            n++;
         end
         if (cyc > 300) begin timeout = 1; break; end
      end
      @(posedge CLOCK_50);
   endtask

   task automatic test_reset;
      reset = 1'b0; motor_state = 5'b10000; speed = 8'h64; tx_ready = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      checks++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", tx_valid); end
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (frame_count !== 16'd0) begin errs++; $display("FAIL reset_fc got=%0d exp=0", frame_count); end
      checks++; if (tx_data !== 8'h00) begin errs++; $display("FAIL reset_data got=%h exp=00", tx_data); end
   endtask

   task automatic test_first_frame;
      reset = 1'b1;
      collect(100, -1, 5'b0);
      exp_fc++; last_sent = 8'h04;
      checks++; if (timeout || {got[0], got[1], got[2], got[3]} !== 32'hAA0464CA) begin
         errs++; $display("FAIL first_frame got=%h%h%h%h exp=AA0464CA", got[0], got[1], got[2], got[3]); end
      checks++; if (first_cyc != 1) begin errs++; $display("FAIL first_latency got=%0d exp=1", first_cyc); end
      checks++; if (last_cyc - first_cyc != 3) begin errs++; $display("FAIL first_b2b got=%0d exp=3", last_cyc - first_cyc); end
      @(negedge CLOCK_50);
      checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errs++; $display("FAIL first_idle got busy=%b valid=%b exp=0/0", busy, tx_valid); end
      checks++; if (frame_count !== 16'(exp_fc)) begin errs++; $display("FAIL first_fc got=%0d exp=%0d", frame_count, exp_fc); end
   endtask

   task automatic test_change_and_refresh;
      motor_state = 5'b00010;
      collect(100, -1, 5'b0);
      exp_fc++; last_sent = 8'h01;
      checks++; if (timeout || {got[0], got[1], got[2], got[3]} !== 32'hAA0164CF) begin
         errs++; $display("FAIL change_frame got=%h%h%h%h exp=AA0164CF", got[0], got[1], got[2], got[3]); end
      checks++; if (first_cyc != 1) begin errs++; $display("FAIL change_latency got=%0d exp=1", first_cyc); end
      collect(100, -1, 5'b0);
      exp_fc++;
      checks++; if (timeout || {got[0], got[1], got[2], got[3]} !== 32'hAA0164CF) begin
         errs++; $display("FAIL refresh_frame got=%h%h%h%h exp=AA0164CF", got[0], got[1], got[2], got[3]); end
      checks++; if (first_cyc != REF + 1) begin errs++; $display("FAIL refresh_gap got=%0d exp=%0d", first_cyc, REF + 1); end
      @(negedge CLOCK_50);
      checks++; if (frame_count !== 16'(exp_fc)) begin errs++; $display("FAIL refresh_fc got=%0d exp=%0d", frame_count, exp_fc); end
   endtask

   task automatic test_stall;
      int n = 0;
      int cyc = 0;
      int stall = 0;
      int bad = 0;
      motor_state = 5'b00100;
      for (int i = 0; i < 4; i++) got[i] = 'x;
      while (n < 4 && cyc < 100) begin
         @(negedge CLOCK_50); cyc++;
         if (n == 1 && stall < 7) begin
            tx_ready = 1'b0; stall++;
            if (!(tx_valid === 1'b1 && tx_data === 8'h02)) bad++;
         end else tx_ready = 1'b1;
         if (tx_valid && tx_ready) begin got[n] = tx_data; n++; end
      end
      @(posedge CLOCK_50);
      exp_fc++; last_sent = 8'h02;
      checks++; if (bad != 0 || stall != 7) begin errs++; $display("FAIL stall_hold got bad=%0d stalls=%0d exp 0/7", bad, stall); end
      checks++; if ({got[0], got[1], got[2], got[3]} !== 32'hAA0264CC) begin
         errs++; $display("FAIL stall_frame got=%h%h%h%h exp=AA0264CC", got[0], got[1], got[2], got[3]); end
      @(negedge CLOCK_50);
      checks++; if (frame_count !== 16'(exp_fc)) begin errs++; $display("FAIL stall_fc got=%0d exp=%0d", frame_count, exp_fc); end
   endtask

   task automatic test_pending;
      motor_state = 5'b00010;
      collect(100, 2, 5'b01000);
      exp_fc++;
      checks++; if (timeout || {got[0], got[1], got[2], got[3]} !== 32'hAA0164CF) begin
         errs++; $display("FAIL pend_first got=%h%h%h%h exp=AA0164CF", got[0], got[1], got[2], got[3]); end
      collect(100, -1, 5'b0);
      exp_fc++; last_sent = 8'h03;
      checks++; if (timeout || {got[0], got[1], got[2], got[3]} !== 32'hAA0364CD) begin
         errs++; $display("FAIL pend_second got=%h%h%h%h exp=AA0364CD", got[0], got[1], got[2], got[3]); end
      checks++; if (first_cyc != 2) begin errs++; $display("FAIL pend_gap got=%0d exp=2", first_cyc); end
      @(negedge CLOCK_50);
      checks++; if (frame_count !== 16'(exp_fc)) begin errs++; $display("FAIL pend_fc got=%0d exp=%0d", frame_count, exp_fc); end
   endtask

   task automatic test_invalid_refresh;
      motor_state = 5'b00110; speed = 8'h64;
      collect(100, -1, 5'b0);
      exp_fc++; last_sent = 8'h00;
      checks++; if (timeout || {got[0], got[1], got[2], got[3]} !== 32'hAA0064CE) begin
         errs++; $display("FAIL invalid_frame got=%h%h%h%h exp=AA0064CE", got[0], got[1], got[2], got[3]); end
      collect(100, -1, 5'b0);
      exp_fc++;
      checks++; if (timeout || {got[0], got[1], got[2], got[3]} !== 32'hAA0064CE || first_cyc != REF + 1) begin
         errs++; $display("FAIL invalid_refresh got=%h%h%h%h gap=%0d exp=AA0064CE gap=%0d", got[0], got[1], got[2], got[3], first_cyc, REF + 1); end
      @(negedge CLOCK_50);
      speed = 8'h33;
      collect(100, -1, 5'b0);
      exp_fc++;
      checks++; if (timeout || {got[0], got[1], got[2], got[3]} !== ref_frame(5'b00110, 8'h33) || first_cyc != REF) begin
         errs++; $display("FAIL speed_refresh got=%h%h%h%h gap=%0d exp=%h gap=%0d", got[0], got[1], got[2], got[3], first_cyc, ref_frame(5'b00110, 8'h33), REF); end
      @(negedge CLOCK_50);
      checks++; if (frame_count !== 16'(exp_fc)) begin errs++; $display("FAIL refresh_count got=%0d exp=%0d", frame_count, exp_fc); end
   endtask

   task automatic test_reset_midframe;
      int n = 0;
      motor_state = 5'b10000; speed = 8'h5A;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge CLOCK_50);
         tx_ready = 1'b1;
         if (n == 1) begin reset = 1'b0; break; end
         if (tx_valid && tx_ready) n++;
      end
      #1;
      exp_fc = 0;
      checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL abort_valid got valid=%b busy=%b exp=0/0", tx_valid, busy); end
      checks++; if (frame_count !== 16'd0) begin errs++; $display("FAIL abort_fc got=%0d exp=0", frame_count); end
      @(negedge CLOCK_50);
      reset = 1'b1;
      collect(100, -1, 5'b0);
      exp_fc++; last_sent = 8'h04;
      checks++; if (timeout || {got[0], got[1], got[2], got[3]} !== ref_frame(5'b10000, 8'h5A) || first_cyc != 1) begin
         errs++; $display("FAIL abort_refrm got=%h%h%h%h lat=%0d exp=%h lat=1", got[0], got[1], got[2], got[3], first_cyc, ref_frame(5'b10000, 8'h5A)); end
      @(negedge CLOCK_50);
      checks++; if (frame_count !== 16'(exp_fc)) begin errs++; $display("FAIL abort_fc2 got=%0d exp=%0d", frame_count, exp_fc); end
   endtask

   task automatic test_random;
      logic [4:0] ms, ms2;
      logic [7:0] sp;
      int         chg;
      for (int it = 0; it < 30; it++) begin
         do begin
            ms = ($urandom_range(1) != 0) ? 5'(5'b1 << $urandom_range(4)) : 5'($urandom_range(31));
         end while (ref_code(ms) == last_sent);
         sp  = 8'($urandom_range(255));
         chg = ($urandom_range(1) != 0) ? int'($urandom_range(1, 3)) : -1;
         do begin
            ms2 = 5'($urandom_range(31));
         end while (ref_code(ms2) == ref_code(ms));
         @(negedge CLOCK_50);
         motor_state = ms; speed = sp;
         collect(int'($urandom_range(30, 100)), chg, ms2);
         exp_fc++; last_sent = ref_code(ms);
         checks++; if (timeout || {got[0], got[1], got[2], got[3]} !== ref_frame(ms, sp)) begin
            errs++; $display("FAIL rand_frame it=%0d got=%h%h%h%h exp=%h", it, got[0], got[1], got[2], got[3], ref_frame(ms, sp)); end
         if (chg >= 0) begin
            collect(int'($urandom_range(30, 100)), -1, 5'b0);
            exp_fc++; last_sent = ref_code(ms2);
            checks++; if (timeout || {got[0], got[1], got[2], got[3]} !== ref_frame(ms2, sp)) begin
               errs++; $display("FAIL rand_pend it=%0d got=%h%h%h%h exp=%h", it, got[0], got[1], got[2], got[3], ref_frame(ms2, sp)); end
         end
         @(negedge CLOCK_50);
         checks++; if (frame_count !== 16'(exp_fc) || busy !== 1'b0) begin
            errs++; $display("FAIL rand_fc it=%0d got=%0d busy=%b exp=%0d busy=0", it, frame_count, busy, exp_fc); end
      end
   endtask

   initial begin
      test_reset;
      test_first_frame;
      test_change_and_refresh;
      test_stall;
      test_pending;
      test_invalid_refresh;
      test_reset_midframe;
      test_random;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/motor_cmd_framer.md
Name: motor_cmd_framer

Overview:
- Converts the one-hot motor_state command into a 4-byte serial command frame for the UART transmitter.
- Sits between the motor-state decision logic (upstream) and the uart_tx byte interface inside top_level (downstream).
- Emits a frame on every command change, once after reset, and periodically as a keep-alive so the motor controller never times out.

Parameters:
- HEADER, 8'hAA, frame start byte.
- REFRESH_CYCLES, 5_000_000, idle cycles before a keep-alive resend; 0 disables refresh.
- CNT_W, 24, width of the refresh counter; must hold REFRESH_CYCLES.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- motor_state  input  5  one-hot command: bit0 stop, bit1 forward, bit2 right, bit3 left, bit4 spin; synchronous to CLOCK_50.
- speed  input  8  speed byte; latched at frame start.
- tx_data  output  8  byte offered to the UART transmitter.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  UART transmitter accepts the byte this cycle.
- busy  output  1  high while a frame is in progress.
- frame_count  output  16  number of completed frames; wraps at 0xFFFF->0.

Behaviour:
- Reset (async assert, sync use): state=IDLE, tx_data=0, tx_valid=0, busy=0, frame_count=0, refresh counter=0, pending=0. last_code is set to 3'h7, an invalid code, which forces one frame after reset.
- Code map: stop=0x00, forward=0x01, right=0x02, left=0x03, spin=0x04. Any non-one-hot motor_state, including 0 or multiple bits set, maps to stop (0x00).
- Frame format, in order: HEADER, CMD, SPEED, CHK, where CHK = HEADER ^ CMD ^ SPEED.
- FSM states: IDLE -> HDR -> CMD -> SPD -> CHK -> IDLE.
- IDLE start condition (any of):
  - code(motor_state) != last_code, or
  - pending=1, or
  - refresh expiry.
- On the start edge:
  - latch CMD=code(motor_state) and SPEED=speed;
  - set last_code=CMD; clear pending and the refresh counter;
  - move to HDR with tx_data=HEADER and tx_valid=1 on the same edge.
  - Latency from the sampling edge to tx_valid visible is 1 cycle.
- Byte handshake:
  - In HDR/CMD/SPD/CHK, tx_data and tx_valid are held stable until a rising edge with tx_valid&&tx_ready.
  - On acceptance, advance state and present the next byte on that same edge, so bytes can go back-to-back with no gap.
  - tx_ready while tx_valid=0 has no effect.
- Frame end: on CHK acceptance, go to IDLE, tx_valid=0, frame_count+=1. IDLE is held at least 1 cycle between frames.
- busy = (state != IDLE).
- Mid-frame command change: the frame in flight completes with its latched CMD/SPEED. If code(motor_state) != latched CMD on any busy cycle, set pending=1. The next frame starts on the first IDLE cycle and uses the motor_state value present then.
- Change-and-revert mid-frame: pending stays set, so a duplicate frame is sent. This is accepted behaviour.
- Refresh:
  - The counter increments only in IDLE.
  - Expiry when the count reaches REFRESH_CYCLES-1; the frame starts on the next edge.
  - The counter clears on every frame start.
  - REFRESH_CYCLES=0 disables refresh.
- speed changes alone do not trigger a frame; they are sent on the next change or refresh frame.
- Reset asserted mid-frame: abort immediately, drop tx_valid, and return to reset values. A fresh frame follows release.
- tx_ready held low indefinitely: the block stalls in its current state with tx_valid=1 and no timeout.

Test Plan:
- Reset release with motor_state=5'b10000, speed=0x64, tx_ready=1 -> bytes AA 04 64 CA, tx_valid high on 4 consecutive cycles starting 1 cycle after release, then frame_count=1, busy=0.
- After the spin frame, change motor_state to 5'b00010 -> exactly one frame AA 01 64 CF, then no further output for REFRESH_CYCLES-1 idle cycles.
- tx_ready low for 7 cycles during the CMD byte with motor_state=5'b00100 -> tx_data stays 0x02 and tx_valid stays 1 throughout; completed frame is AA 02 64 CC.
- Change motor_state from forward to left during the SPD byte -> the current frame finishes as AA 01 64 CF; after 1 idle cycle, AA 03 64 CD is sent.
- motor_state=5'b00110 (invalid), speed=0x64 -> frame AA 00 64 CE. Set REFRESH_CYCLES=20 with no changes -> an identical frame repeats every 20 idle cycles plus frame time, and frame_count increments each time.
- Assert reset during the CMD byte -> tx_valid=0 and frame_count=0 immediately. On release, a complete frame for the current motor_state is sent.
